// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
//   Takes the PLL lock indication and qualifies it. It then generates the
//   sequenced system reset and the divided clock-enable strobes used by the
//   game cores. Any loss of lock in HOLD/RUN sends the block back through a
//   full qualification and bumps a saturating debug counter.
//
// Ports
//   clk            60 MHz PLL output clock
//   rst            synchronous active-high reset
//   locked         PLL locked, asynchronous to clk (synchronized internally)
//   sys_rst        registered active-high reset to game logic
//   ready          high while the sequencer is in RUN
//   cen0/1/2       single-cycle enables with periods DIV0/DIV1/DIV2
//   lock_loss_cnt  saturating count of lock losses seen in HOLD/RUN
module pll_lock_sequencer #(
  parameter logic [15:0] STABLE_CYC = 16'd1024,
  parameter logic [15:0] RESET_CYC  = 16'd256,
  parameter logic [15:0] DIV0       = 16'd10,
  parameter logic [15:0] DIV1       = 16'd12,
  parameter logic [15:0] DIV2       = 16'd40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       locked,
  output logic       sys_rst,
  output logic       ready,
  output logic       cen0,
  output logic       cen1,
  output logic       cen2,
  output logic [7:0] lock_loss_cnt
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam logic [2:0][15:0] DIV_TAB = {DIV2, DIV1, DIV0};

  state_t      state_reg, state_next;
  logic [1:0]  sync_reg;
  logic        locked_s;
  logic [15:0] stab_cnt_reg, stab_cnt_next;
  logic [15:0] rst_cnt_reg, rst_cnt_next;
  logic [7:0]  loss_cnt_reg, loss_cnt_next;
  logic        sys_rst_reg, ready_reg;
  logic        div_run;
  logic [2:0]  cen_vec;

  // Two-stage synchronizer for the asynchronous lock input.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], locked};
    end
  end

  assign locked_s = sync_reg[1];

  // Next-state logic. Loss of lock is tested before the HOLD terminal count
  // so a simultaneous loss always wins.
  always_comb begin
    state_next    = state_reg;
    stab_cnt_next = stab_cnt_reg;
    rst_cnt_next  = rst_cnt_reg;
    loss_cnt_next = loss_cnt_reg;
    case (state_reg)
      WAIT_LOCK: begin
        stab_cnt_next = 16'd0;
        if (locked_s) begin
          state_next = STABLE;
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_next    = WAIT_LOCK;
          stab_cnt_next = 16'd0;
        end else if (stab_cnt_reg == STABLE_CYC - 16'd1) begin
          state_next    = HOLD;
          stab_cnt_next = 16'd0;
          rst_cnt_next  = 16'd0;
        end else begin
          stab_cnt_next = stab_cnt_reg + 16'd1;
        end
      end
      HOLD: begin
        if (!locked_s) begin
          state_next = WAIT_LOCK;
          if (loss_cnt_reg != 8'hFF) begin
            loss_cnt_next = loss_cnt_reg + 8'd1;
          end
        end else if (rst_cnt_reg == RESET_CYC - 16'd1) begin
          state_next = RUN;
        end else begin
          rst_cnt_next = rst_cnt_reg + 16'd1;
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_next = WAIT_LOCK;
          if (loss_cnt_reg != 8'hFF) begin
            loss_cnt_next = loss_cnt_reg + 8'd1;
          end
        end
      end
      default: begin
        state_next = WAIT_LOCK;
      end
    endcase
  end

  // State and registered outputs; outputs are derived from the next state so
  // they change on the same edge as the state itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= WAIT_LOCK;
      stab_cnt_reg <= 16'd0;
      rst_cnt_reg  <= 16'd0;
      loss_cnt_reg <= 8'd0;
      sys_rst_reg  <= 1'b1;
      ready_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      stab_cnt_reg <= stab_cnt_next;
      rst_cnt_reg  <= rst_cnt_next;
      loss_cnt_reg <= loss_cnt_next;
      sys_rst_reg  <= (state_next != RUN);
      ready_reg    <= (state_next == RUN);
    end
  end

  // Dividers advance only while staying within HOLD/RUN. The HOLD-entry edge
  // and any exit edge clear them, giving a deterministic phase on every lock.
  assign div_run = ((state_reg == HOLD) || (state_reg == RUN)) &&
                   ((state_next == HOLD) || (state_next == RUN));

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_div
      logic [15:0] cnt_reg;
      logic        cen_reg;

      always_ff @(posedge clk) begin
        if (rst || !div_run) begin
          cnt_reg <= 16'd0;
          cen_reg <= 1'b0;
        end else if (cnt_reg == DIV_TAB[gi] - 16'd1) begin
          cnt_reg <= 16'd0;
          cen_reg <= 1'b1;
        end else begin
          cnt_reg <= cnt_reg + 16'd1;
          cen_reg <= 1'b0;
        end
      end

      assign cen_vec[gi] = cen_reg;
    end
  endgenerate

  assign sys_rst       = sys_rst_reg;
  assign ready         = ready_reg;
  assign cen0          = cen_vec[0];
  assign cen1          = cen_vec[1];
  assign cen2          = cen_vec[2];
  assign lock_loss_cnt = loss_cnt_reg;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with short qualification/reset counts.
module tb_pll_lock_sequencer;

  logic       clk;
  logic       rst;
  logic       locked;
  logic       sys_rst;
  logic       ready;
  logic       cen0;
  logic       cen1;
  logic       cen2;
  logic [7:0] lock_loss_cnt;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_loss = 8'd0;

  pll_lock_sequencer #(
    .STABLE_CYC(16'd4),
    .RESET_CYC (16'd8),
    .DIV0      (16'd10),
    .DIV1      (16'd12),
    .DIV2      (16'd40)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .locked       (locked),
    .sys_rst      (sys_rst),
    .ready        (ready),
    .cen0         (cen0),
    .cen1         (cen1),
    .cen2         (cen2),
    .lock_loss_cnt(lock_loss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and sample 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int e, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, e, obs, exp);
    end
  endtask

  // Lock from WAIT_LOCK with locked held high: E0 is the next edge.
  // RUN at E14; cen0 from E16 every 10, cen1 from E18 every 12, cen2 from E46.
  task automatic run_sequence(input int n, input string name);
    locked = 1'b1;
    for (int e = 0; e < n; e++) begin
      step();
      chk("sys_rst", e, 32'(sys_rst), 32'(e < 14));
      chk("ready",   e, 32'(ready),   32'(e >= 14));
      chk("cen0",    e, 32'(cen0),    32'((e >= 16) && ((e - 16) % 10 == 0)));
      chk("cen1",    e, 32'(cen1),    32'((e >= 18) && ((e - 18) % 12 == 0)));
      chk("cen2",    e, 32'(cen2),    32'((e >= 46) && ((e - 46) % 40 == 0)));
      chk("loss_cnt", e, 32'(lock_loss_cnt), 32'(exp_loss));
    end
    $display("sequence %s: %0d edges checked", name, n);
  endtask

  initial begin
    rst    = 1'b1;
    locked = 1'b0;

    // 1: reset then lock-up timing
    repeat (3) step();
    chk("rst_sys_rst", 0, 32'(sys_rst), 32'd1);
    chk("rst_ready",   0, 32'(ready),   32'd0);
    chk("rst_cen",     0, 32'({cen2, cen1, cen0}), 32'd0);
    chk("rst_loss",    0, 32'(lock_loss_cnt), 32'd0);
    rst = 1'b0;
    run_sequence(61, "initial_lock");

    // 3: loss of lock in RUN, then identical re-lock
    locked = 1'b0;
    step();
    step();
    chk("run_loss_ready_hold", 1, 32'(ready), 32'd1);
    step();
    exp_loss = 8'd1;
    chk("run_loss_sys_rst", 2, 32'(sys_rst), 32'd1);
    chk("run_loss_ready",   2, 32'(ready),   32'd0);
    chk("run_loss_cen",     2, 32'({cen2, cen1, cen0}), 32'd0);
    chk("run_loss_cnt",     2, 32'(lock_loss_cnt), 32'(exp_loss));
    run_sequence(61, "relock_after_run_loss");

    // Return to WAIT_LOCK before the HOLD tests
    locked = 1'b0;
    repeat (3) step();
    exp_loss = exp_loss + 8'd1;
    chk("prelude_loss_cnt", 2, 32'(lock_loss_cnt), 32'(exp_loss));

    // 4a: loss while rst_cnt==5 (HOLD from E6, loss edge E12)
    locked = 1'b1;
    for (int e = 0; e <= 20; e++) begin
      step();
      chk("hold5_sys_rst", e, 32'(sys_rst), 32'd1);
      chk("hold5_ready",   e, 32'(ready),   32'd0);
      chk("hold5_cen0",    e, 32'(cen0),    32'd0);
      chk("hold5_loss",    e, 32'(lock_loss_cnt),
          32'((e >= 12) ? exp_loss + 8'd1 : exp_loss));
      if (e == 9) locked = 1'b0;
    end
    exp_loss = exp_loss + 8'd1;
    $display("hold loss at rst_cnt=5: loss_cnt=%0d", lock_loss_cnt);

    // 4b: loss on the rst_cnt==7 cycle (terminal); loss must win at E14
    locked = 1'b1;
    for (int e = 0; e <= 20; e++) begin
      step();
      chk("hold7_sys_rst", e, 32'(sys_rst), 32'd1);
      chk("hold7_ready",   e, 32'(ready),   32'd0);
      chk("hold7_loss",    e, 32'(lock_loss_cnt),
          32'((e >= 14) ? exp_loss + 8'd1 : exp_loss));
      if (e == 11) locked = 1'b0;
    end
    exp_loss = exp_loss + 8'd1;
    $display("hold loss at rst_cnt=7: loss_cnt=%0d", lock_loss_cnt);

    // 5: saturation over 260 lock/loss cycles (loss edge is E9 each time)
    for (int i = 0; i < 260; i++) begin
      locked = 1'b1;
      repeat (7) step();
      locked = 1'b0;
      repeat (3) step();
      if (exp_loss != 8'hFF) exp_loss = exp_loss + 8'd1;
      chk("sat_loss_cnt", i, 32'(lock_loss_cnt), 32'(exp_loss));
    end
    chk("sat_final", 0, 32'(lock_loss_cnt), 32'hFF);
    $display("saturation: loss_cnt=%0h", lock_loss_cnt);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_loss = 8'd0;
    chk("sat_rst_clear",   0, 32'(lock_loss_cnt), 32'd0);
    chk("sat_rst_sys_rst", 0, 32'(sys_rst), 32'd1);

    // 2: glitch rejection; STABLE E2, WAIT E5, STABLE E6, HOLD E10, RUN E18
    locked = 1'b1;
    for (int e = 0; e <= 24; e++) begin
      step();
      if (e == 2) locked = 1'b0;
      if (e == 3) locked = 1'b1;
      chk("glitch_sys_rst", e, 32'(sys_rst), 32'(e < 18));
      chk("glitch_ready",   e, 32'(ready),   32'(e >= 18));
      chk("glitch_cen0",    e, 32'(cen0),    32'(e == 20));
      chk("glitch_cen1",    e, 32'(cen1),    32'(e == 22));
      chk("glitch_cen2",    e, 32'(cen2),    32'd0);
      chk("glitch_loss",    e, 32'(lock_loss_cnt), 32'd0);
    end
    $display("glitch rejection: ready=%0b", ready);

    // 6: reset mid-RUN with locked held high
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_sys_rst", 0, 32'(sys_rst), 32'd1);
    chk("midrst_ready",   0, 32'(ready),   32'd0);
    chk("midrst_cen",     0, 32'({cen2, cen1, cen0}), 32'd0);
    chk("midrst_loss",    0, 32'(lock_loss_cnt), 32'd0);
    run_sequence(20, "after_mid_run_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
